// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo
//   Serial echo engine: a UART receiver feeds characters into a circular FIFO
//   and a UART transmitter drains it, so every correctly framed character
//   received on `in` is retransmitted on `out` in order. Back-to-back input
//   and transmit stalls (tx_pause) are absorbed by the FIFO.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (>= 4)
//   DATA_BITS     data bits per character (5..9), LSB first
//   FIFO_AW       FIFO address width, depth = 2**FIFO_AW
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   in          serial RX line (idles high, asynchronous to clk)
//   out         serial TX line (idles high)
//   tx_pause    holds TX in IDLE; a frame in progress still completes
//   clr_err     synchronous clear of the sticky error flags
//   fifo_count  characters currently held in the FIFO
//   rx_busy     RX FSM not in IDLE (registered)
//   tx_busy     TX FSM not in IDLE (registered)
//   overflow    sticky: good character dropped because the FIFO was full
//   frame_err   sticky: stop bit sampled low
//   parity_err  sticky: parity mismatch (constant 0 without parity)
//
// Build option
//   UART_ECHO_PARITY_EN  when defined, both directions carry an even-parity
//                        bit between the data and the stop bit.

module uart_echo_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_AW      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  output logic             out,
  input  logic             tx_pause,
  input  logic             clr_err,
  output logic [FIFO_AW:0] fifo_count,
  output logic             rx_busy,
  output logic             tx_busy,
  output logic             overflow,
  output logic             frame_err,
  output logic             parity_err
);

  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int BW    = $clog2(DATA_BITS);
  localparam int DEPTH = 2 ** FIFO_AW;

  localparam logic [CW-1:0]    BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    HALF_LAST  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0]    DATA_LAST  = BW'(DATA_BITS - 1);
  localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_ECHO_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  // ---------------- input synchroniser + falling-edge detect ----------------
  logic in_meta_reg, in_sync_reg, in_prev_reg;
  logic start_edge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_meta_reg <= 1'b1;
      in_sync_reg <= 1'b1;
      in_prev_reg <= 1'b1;
    end else begin
      in_meta_reg <= in;
      in_sync_reg <= in_meta_reg;
      in_prev_reg <= in_sync_reg;
    end
  end

  // Edge (not level) so a line held low after a framing error cannot retrigger.
  assign start_edge = in_prev_reg & ~in_sync_reg;

  // ---------------- RX FSM ----------------
  logic [2:0]           rx_state_reg, rx_state_next;
  logic [CW-1:0]        rx_cnt_reg, rx_cnt_next;
  logic [BW-1:0]        rx_bit_reg, rx_bit_next;
  logic [DATA_BITS-1:0] rx_shift_reg, rx_shift_next;
  logic                 push_req, frame_set;
`ifdef UART_ECHO_PARITY_EN
  logic                 rx_par_bad_reg, rx_par_bad_next;
  logic                 parity_set;
`endif

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    push_req      = 1'b0;
    frame_set     = 1'b0;
`ifdef UART_ECHO_PARITY_EN
    rx_par_bad_next = rx_par_bad_reg;
    parity_set      = 1'b0;
`endif
    case (rx_state_reg)
      S_IDLE: begin
        if (start_edge) begin
          rx_state_next = S_START;
          rx_cnt_next   = '0;
          rx_bit_next   = '0;
        end
      end
      S_START: begin
        if (rx_cnt_reg == HALF_LAST) begin
          rx_cnt_next   = '0;
          // A high sample at mid start bit is a glitch: drop back quietly.
          rx_state_next = in_sync_reg ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      S_DATA: begin
        if (rx_cnt_reg == BIT_LAST) begin
          rx_cnt_next   = '0;
          rx_shift_next = {in_sync_reg, rx_shift_reg[DATA_BITS-1:1]};
          if (rx_bit_reg == DATA_LAST) begin
`ifdef UART_ECHO_PARITY_EN
            rx_state_next = S_PARITY;
`else
            rx_state_next = S_STOP;
`endif
          end else begin
            rx_bit_next = rx_bit_reg + 1'b1;
          end
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
`ifdef UART_ECHO_PARITY_EN
      S_PARITY: begin
        if (rx_cnt_reg == BIT_LAST) begin
          rx_cnt_next     = '0;
          rx_par_bad_next = in_sync_reg ^ (^rx_shift_reg);
          rx_state_next   = S_STOP;
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (rx_cnt_reg == BIT_LAST) begin
          rx_cnt_next   = '0;
          rx_state_next = S_IDLE;
          if (!in_sync_reg) begin
            frame_set = 1'b1;
`ifdef UART_ECHO_PARITY_EN
          end else if (rx_par_bad_reg) begin
            parity_set = 1'b1;
`endif
          end else begin
            push_req = 1'b1;
          end
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      default: rx_state_next = S_IDLE;
    endcase
  end

  // ---------------- FIFO ----------------
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [DATA_BITS-1:0] rd_data_reg;
  logic [FIFO_AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_AW:0]     count_reg;
  logic                 pop, push_ok, overflow_set;

  // A full FIFO still takes a push when the same cycle pops.
  assign push_ok      = push_req & ((count_reg != FULL_COUNT) | pop);
  assign overflow_set = push_req & ~push_ok;

  // Storage has no reset so it maps onto block RAM; read is registered on pop.
  // When full with a simultaneous push, this reads the old entry first.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= rx_shift_reg;
    if (pop)     rd_data_reg     <= mem[rd_ptr_reg];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  logic [2:0]    tx_state_reg, tx_state_next;
  logic [CW-1:0] tx_cnt_reg, tx_cnt_next;
  logic [BW-1:0] tx_bit_reg, tx_bit_next;
  logic          out_reg, out_next;
  logic          tx_eval_idle;

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg;
    tx_bit_next   = tx_bit_reg;
    out_next      = out_reg;
    tx_eval_idle  = 1'b0;
    pop           = 1'b0;
    case (tx_state_reg)
      S_IDLE: tx_eval_idle = 1'b1;
      S_START: begin
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next   = '0;
          tx_bit_next   = '0;
          tx_state_next = S_DATA;
          out_next      = rd_data_reg[0];
        end else begin
          tx_cnt_next = tx_cnt_reg + 1'b1;
        end
      end
      S_DATA: begin
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next = '0;
          if (tx_bit_reg == DATA_LAST) begin
`ifdef UART_ECHO_PARITY_EN
            tx_state_next = S_PARITY;
            out_next      = ^rd_data_reg;
`else
            tx_state_next = S_STOP;
            out_next      = 1'b1;
`endif
          end else begin
            tx_bit_next = tx_bit_reg + 1'b1;
            out_next    = rd_data_reg[tx_bit_next];
          end
        end else begin
          tx_cnt_next = tx_cnt_reg + 1'b1;
        end
      end
`ifdef UART_ECHO_PARITY_EN
      S_PARITY: begin
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next   = '0;
          tx_state_next = S_STOP;
          out_next      = 1'b1;
        end else begin
          tx_cnt_next = tx_cnt_reg + 1'b1;
        end
      end
`endif
      S_STOP: begin
        // Last stop cycle behaves like IDLE so queued data goes out gap-free.
        if (tx_cnt_reg == BIT_LAST) tx_eval_idle = 1'b1;
        else                        tx_cnt_next  = tx_cnt_reg + 1'b1;
      end
      default: tx_state_next = S_IDLE;
    endcase

    if (tx_eval_idle) begin
      tx_cnt_next = '0;
      if ((count_reg != '0) && !tx_pause) begin
        pop           = 1'b1;
        tx_state_next = S_START;
        out_next      = 1'b0;
      end else begin
        tx_state_next = S_IDLE;
        out_next      = 1'b1;
      end
    end
  end

  // ---------------- state registers, busy and error flags ----------------
  logic rx_busy_reg, tx_busy_reg, overflow_reg, frame_err_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_reg  <= S_IDLE;
      rx_cnt_reg    <= '0;
      rx_bit_reg    <= '0;
      rx_shift_reg  <= '0;
      tx_state_reg  <= S_IDLE;
      tx_cnt_reg    <= '0;
      tx_bit_reg    <= '0;
      out_reg       <= 1'b1;
      rx_busy_reg   <= 1'b0;
      tx_busy_reg   <= 1'b0;
      overflow_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      out_reg      <= out_next;
      // Registered from the next state so busy lines up with the state register.
      rx_busy_reg  <= (rx_state_next != S_IDLE);
      tx_busy_reg  <= (tx_state_next != S_IDLE);
      // A new error outranks a simultaneous clear.
      if (overflow_set) overflow_reg <= 1'b1;
      else if (clr_err) overflow_reg <= 1'b0;
      if (frame_set)    frame_err_reg <= 1'b1;
      else if (clr_err) frame_err_reg <= 1'b0;
    end
  end

`ifdef UART_ECHO_PARITY_EN
  logic parity_err_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_par_bad_reg <= 1'b0;
      parity_err_reg <= 1'b0;
    end else begin
      rx_par_bad_reg <= rx_par_bad_next;
      if (parity_set)   parity_err_reg <= 1'b1;
      else if (clr_err) parity_err_reg <= 1'b0;
    end
  end

  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

  assign out        = out_reg;
  assign fifo_count = count_reg;
  assign rx_busy    = rx_busy_reg;
  assign tx_busy    = tx_busy_reg;
  assign overflow   = overflow_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Testbench for uart_echo_fifo (CLKS_PER_BIT=16, DATA_BITS=8, FIFO_AW=4).
// Drives serial frames on `in`, decodes `out` with an independent frame
// monitor, and compares against expectations computed from the UART framing
// rules and a queue model of the FIFO.

module tb_uart_echo_fifo;

  localparam int CPB   = 16;
  localparam int DB    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 2 ** AW;
`ifdef UART_ECHO_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS = DB + 2 + P;
  localparam int FRAME = CPB * NBITS;

  logic          clk;
  logic          reset;
  logic          in_line;
  logic          out;
  logic          tx_pause;
  logic          clr_err;
  logic [AW:0]   fifo_count;
  logic          rx_busy;
  logic          tx_busy;
  logic          overflow;
  logic          frame_err;
  logic          parity_err;

  uart_echo_fifo #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB),
    .FIFO_AW     (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in_line),
    .out       (out),
    .tx_pause  (tx_pause),
    .clr_err   (clr_err),
    .fifo_count(fifo_count),
    .rx_busy   (rx_busy),
    .tx_busy   (tx_busy),
    .overflow  (overflow),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] got_q[$];
  int         start_q[$];
  logic [7:0] exp_q[$];
  int         mon_bad = 0;
`ifdef UART_ECHO_PARITY_EN
  logic       got_par_q[$];
  logic       par_flip_g = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    in_line = b;
    repeat (n) @(negedge clk);
  endtask

  // Start, data LSB first, optional even parity, stop held for stop_cycles.
  task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input int stop_cycles);
    drive_bit(1'b0, CPB);
    for (int j = 0; j < DB; j++) drive_bit(d[j], CPB);
`ifdef UART_ECHO_PARITY_EN
    drive_bit((^d) ^ par_flip_g, CPB);
`endif
    drive_bit(stop_lvl, stop_cycles);
    if (!stop_lvl) drive_bit(1'b1, 2);
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic wait_got(input int n, input int limit, input string tag);
    for (int i = 0; i < limit && got_q.size() < n; i++) @(negedge clk);
    check(tag, got_q.size(), n);
  endtask

  // Expected line level for each bit slot of a frame carrying d.
  function automatic logic [15:0] build_frame(input logic [7:0] d);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int j = 0; j < DB; j++) f[1 + j] = d[j];
`ifdef UART_ECHO_PARITY_EN
    f[DB + 1] = ^d;
`endif
    f[NBITS - 1] = 1'b1;
    return f;
  endfunction

  // Frame monitor on `out`: samples bit centres, aborts on reset.
  initial begin
    int         mon_cnt;
    int         mon_t0;
    int         k;
    bit         mon_active;
    logic [7:0] mon_d;
    mon_cnt = 0; mon_t0 = 0; k = 0; mon_active = 0; mon_d = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_active = 0;
      end else if (!mon_active) begin
        if (out === 1'b0) begin
          mon_active = 1;
          mon_cnt    = 0;
          mon_t0     = cyc;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt % CPB == CPB / 2) begin
          k = mon_cnt / CPB;
          if (k == 0) begin
            if (out !== 1'b0) mon_bad++;
          end else if (k <= DB) begin
            mon_d[k - 1] = out;
`ifdef UART_ECHO_PARITY_EN
          end else if (k == DB + 1) begin
            got_par_q.push_back(out);
`endif
          end else begin
            if (out !== 1'b1) mon_bad++;
            got_q.push_back(mon_d);
            start_q.push_back(mon_t0);
            mon_active = 0;
          end
        end
      end
    end
  end

  initial begin
    logic [15:0] fbits;
    logic [7:0]  d;
    int          seen;
    int          busy_cycles;
    int          low_cycles;
    int          exp_count;
    int          gap;
    bit          exp_ovf;
    bit          exp_ferr;
    bit          bad;

    reset = 1'b1; in_line = 1'b1; tx_pause = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out", out, 1);
    check("rst_count", fifo_count, 0);
    check("rst_rx_busy", rx_busy, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_parity_err", parity_err, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // ---- single 0xA5: push timing and exact output waveform ----
    d = 8'hA5;
    send_frame(d, 1'b1, 1);
    seen = 0;
    for (int i = 0; i < 3 * CPB && seen == 0; i++) begin
      @(negedge clk);
      if (fifo_count == 1) seen = 1;
      else check("a5_out_idle", out, 1);
    end
    check("a5_count_1", seen, 1);
    check("a5_out_at_pop", out, 1);
    @(negedge clk);
    check("a5_count_back_0", fifo_count, 0);
    fbits = build_frame(d);
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("a5_slot%0d_cyc%0d", i / CPB, i % CPB), out, fbits[i / CPB]);
    end
    @(negedge clk);
    check("a5_end_out", out, 1);
    check("a5_end_tx_busy", tx_busy, 0);
    check("a5_got_n", got_q.size(), 1);
    if (got_q.size() > 0) check("a5_got", got_q[0], d);

    // ---- paused burst of 17: overflow, then gap-free in-order drain ----
    got_q.delete(); start_q.delete(); exp_q.delete();
    tx_pause = 1'b1; exp_count = 0; exp_ovf = 0;
    for (int i = 0; i < 17; i++) begin
      d = 8'(i);
      send_frame(d, 1'b1, CPB);
      if (exp_count < DEPTH) begin
        exp_q.push_back(d);
        exp_count++;
      end else begin
        exp_ovf = 1;
      end
    end
    repeat (4) @(negedge clk);
    check("burst_count", fifo_count, exp_count);
    check("burst_overflow", overflow, exp_ovf);
    check("burst_out_paused", out, 1);
    check("burst_tx_idle", tx_busy, 0);
    tx_pause = 1'b0;
    wait_got(exp_q.size(), FRAME * (DEPTH + 1) + 50, "burst_drain_n");
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("burst_data%0d", i), got_q[i], exp_q[i]);
    for (int i = 1; i < start_q.size(); i++)
      check($sformatf("burst_gap%0d", i), start_q[i] - start_q[i - 1], FRAME);
    repeat (CPB) @(negedge clk);
    check("burst_count_end", fifo_count, 0);
    check("burst_no_extra", got_q.size(), exp_q.size());
    clr_pulse();
    check("burst_overflow_clr", overflow, 0);

    // ---- 4-cycle glitch on the line ----
    got_q.delete();
    busy_cycles = 0;
    in_line = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) in_line = 1'b1;
      @(negedge clk);
      if (rx_busy) busy_cycles++;
    end
    check("glitch_busy_seen", busy_cycles > 0, 1);
    check("glitch_busy_le8", busy_cycles <= 8, 1);
    check("glitch_rx_idle", rx_busy, 0);
    check("glitch_count", fifo_count, 0);
    check("glitch_frame_err", frame_err, 0);
    check("glitch_overflow", overflow, 0);

    // ---- 0x3C with a low stop bit ----
    send_frame(8'h3C, 1'b0, CPB);
    check("ferr_set", frame_err, 1);
    check("ferr_count", fifo_count, 0);
    check("ferr_rx_idle", rx_busy, 0);
    clr_pulse();
    check("ferr_clr", frame_err, 0);
    repeat (FRAME) @(negedge clk);
    check("glitch_ferr_no_echo", got_q.size(), 0);

    // ---- random characters, occasional bad stop bits ----
    got_q.delete(); exp_q.delete(); exp_ferr = 0;
    for (int i = 0; i < 12; i++) begin
      d   = 8'($urandom_range(0, 255));
      bad = (i == 5) || ($urandom_range(0, 7) == 0);
      send_frame(d, !bad, CPB);
      if (bad) exp_ferr = 1;
      else     exp_q.push_back(d);
      gap = $urandom_range(0, 20);
      repeat (gap) @(negedge clk);
    end
    wait_got(exp_q.size(), 3 * FRAME, "rand_drain_n");
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("rand_data%0d", i), got_q[i], exp_q[i]);
    check("rand_frame_err", frame_err, exp_ferr);
    check("rand_overflow", overflow, 0);
    clr_pulse();
    check("rand_ferr_clr", frame_err, 0);

    // ---- asynchronous reset in the middle of a TX frame ----
    repeat (FRAME) @(negedge clk);
    got_q.delete();
    tx_pause = 1'b1;
    send_frame(8'h55, 1'b1, CPB);
    send_frame(8'h11, 1'b1, CPB);
    send_frame(8'h22, 1'b1, CPB);
    send_frame(8'h33, 1'b1, CPB);
    repeat (4) @(negedge clk);
    check("rst_mid_count4", fifo_count, 4);
    tx_pause = 1'b0;
    repeat (5 * CPB) @(negedge clk);
    check("rst_mid_tx_busy", tx_busy, 1);
    check("rst_mid_count3", fifo_count, 3);
    #1 reset = 1'b1;
    #1;
    check("rst_async_out", out, 1);
    check("rst_async_count", fifo_count, 0);
    check("rst_async_tx_busy", tx_busy, 0);
    check("rst_async_rx_busy", rx_busy, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    low_cycles = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (out !== 1'b1) low_cycles++;
    end
    check("rst_after_out_low", low_cycles, 0);
    check("rst_after_got", got_q.size(), 0);
    check("rst_after_count", fifo_count, 0);

`ifdef UART_ECHO_PARITY_EN
    // ---- parity: 0x07 good (parity 1), 0x03 with parity 1 bad ----
    got_q.delete(); got_par_q.delete();
    par_flip_g = 1'b0;
    send_frame(8'h07, 1'b1, CPB);
    wait_got(1, 2 * FRAME, "par_good_n");
    if (got_q.size() > 0) check("par_good_data", got_q[0], 8'h07);
    if (got_par_q.size() > 0) check("par_good_bit", got_par_q[0], 1);
    check("par_good_no_err", parity_err, 0);
    par_flip_g = 1'b1;
    send_frame(8'h03, 1'b1, CPB);
    par_flip_g = 1'b0;
    repeat (4) @(negedge clk);
    check("par_bad_err", parity_err, 1);
    check("par_bad_count", fifo_count, 0);
    repeat (2 * FRAME) @(negedge clk);
    check("par_bad_no_echo", got_q.size(), 1);
    clr_pulse();
    check("par_clr", parity_err, 0);
`else
    check("noparity_err_tied", parity_err, 0);
`endif

    check("monitor_framing", mon_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_echo_fifo.md
# uart_echo_fifo

- Parametrised serial echo engine: full UART receiver and transmitter with a FIFO between them.
- Every correctly framed character received on `in` is retransmitted on `out`, in order.
- Back-to-back characters and transmit stalls are absorbed by the FIFO rather than lost.
- Sits at the host-link edge of the MLP design and is the buffered, configurable successor to the single-byte echo path.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per serial bit; 50 MHz / 115200 baud. Must be ≥ 4.
- `DATA_BITS`, 8: data bits per character, 5..9, sent and received LSB first.
- `FIFO_AW`, 4: FIFO address width; depth = 2**FIFO_AW.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in`  in  1  serial RX line; idles high; asynchronous to `clk`.
- `out`  out  1  serial TX line; idles high (never tri-stated).
- `tx_pause`  in  1  while high, TX does not start a new frame; a frame already in progress completes.
- `clr_err`  in  1  synchronous clear of all sticky error flags.
- `fifo_count`  out  FIFO_AW+1  number of characters held.
- `rx_busy`  out  1  RX FSM not in IDLE.
- `tx_busy`  out  1  TX FSM not in IDLE.
- `overflow`  out  1  sticky: a good character was dropped because the FIFO was full.
- `frame_err`  out  1  sticky: stop bit sampled low.
- `parity_err`  out  1  sticky: parity mismatch. Tied 0 unless parity is compiled in.

## Operation
Reset state:
- `reset` high forces, asynchronously: both FSMs to IDLE, FIFO empty (`fifo_count`=0), all error flags 0, `out`=1, `rx_busy`=`tx_busy`=0.
- The 2-FF `in` synchroniser resets to 1.
- Reset mid-frame abandons the frame; no partial character is stored or emitted.

RX FSM (IDLE → START → DATA → [PARITY] → STOP → IDLE):
- IDLE:
  - Falling edge on the synchronised input → START; bit counter cleared.
- START:
  - Wait CLKS_PER_BIT/2 cycles (integer division), then sample.
  - Sample low → DATA; sample high → glitch, back to IDLE, nothing stored.
- DATA:
  - Sample every CLKS_PER_BIT cycles, DATA_BITS samples, shifting in LSB first.
- PARITY:
  - One sample; even parity is expected.
- STOP:
  - Sample once, then go to IDLE. The sample cycle is the *push cycle*.
  - Sample high and parity ok → push the character.
  - Sample low → `frame_err`=1, no push.
  - Parity bad → `parity_err`=1, no push.

FIFO:
- Circular buffer of `DATA_BITS`-wide entries; pointers wrap modulo depth.
- Push is accepted when not full, or when full and a pop occurs in the same cycle.
- Otherwise the push is dropped and `overflow`=1.
- Simultaneous push and pop leaves `fifo_count` unchanged.
- Pop on empty never occurs.

TX FSM (IDLE → START → DATA → [PARITY] → STOP → IDLE):
- IDLE:
  - If FIFO not empty and `tx_pause`=0: pop, load the shifter, go to START.
  - `out` goes low on the next cycle.
- Bit durations:
  - START, each DATA bit, PARITY and STOP each drive `out` for exactly CLKS_PER_BIT cycles.
  - Data is sent LSB first.
- End of STOP:
  - IDLE evaluates in the same cycle, so queued characters go out with zero idle gap.

Error flags:
- Sticky until `clr_err` (synchronous) or `reset`.
- When `clr_err` coincides with a new error, the set wins.

## Timing
- Frame length: CLKS_PER_BIT × (DATA_BITS + 2 + P), where P=1 when parity is compiled in, else 0.
- Echo latency, with FIFO empty, TX idle and `tx_pause`=0:
  - `fifo_count` becomes 1 on push cycle +1, when the pop is issued.
  - `out` falls on push cycle +2.
  - `fifo_count` returns to 0 on push cycle +2.
- RX detection: the start edge is seen 2 cycles after the line falls (synchroniser); data samples are at bit centres relative to that point.
- `tx_pause` is sampled only in TX IDLE; it has no effect mid-frame.
- `rx_busy` and `tx_busy` are registered from the FSM states.

## Configuration
- Macro: `UART_ECHO_PARITY_EN`.
- Defined:
  - RX expects one even-parity bit between data and stop; a mismatch sets `parity_err` and drops the character.
  - TX inserts the even-parity bit (XOR of the data bits).
- Undefined:
  - No parity state in either FSM.
  - `parity_err` is constant 0.

## Test plan
CLKS_PER_BIT=16, DATA_BITS=8, FIFO_AW=4 for all scenarios.

- Single 0xA5 on `in`:
  - `out` emits start, then bits 1,0,1,0,0,1,0,1, then stop.
  - `out` falls exactly push cycle +2.
  - `fifo_count` goes 0→1→0.
- `tx_pause`=1 and 17 back-to-back characters 0x00..0x10:
  - `fifo_count`=16, `overflow`=1, 0x10 dropped.
  - Release `tx_pause`: 0x00..0x0F are echoed in order, gap-free, 160 cycles per frame.
- `in` low for 4 cycles, then high:
  - RX returns to IDLE with nothing stored.
  - `rx_busy` drops within 8 cycles of START entry.
  - `fifo_count`=0, no flags.
- Frame 0x3C with stop bit driven low:
  - `frame_err`=1, `fifo_count` unchanged.
  - A `clr_err` pulse clears `frame_err` the next cycle.
- Assert `reset` mid-way through TX of 0x55 with 3 characters queued:
  - `out`=1, `fifo_count`=0, `tx_busy`=0 immediately, without waiting for a clock edge.
  - After release, nothing is emitted.
- With `UART_ECHO_PARITY_EN` defined:
  - 0x07 with parity 1 is accepted and echoed with parity bit 1.
  - 0x03 with parity 1 sets `parity_err`=1 and is not echoed.
